// File: rtl/agc_atten_writer.sv
// agc_atten_writer: programs a serial digital step attenuator from the AGC loop output.
//
// Each write shifts an ATT_BITS word out MSB first on sclk/sdata. It then pulses le to
// latch the word, and then waits out a settle holdoff before the next write can start.
// Updates that arrive while a write is in flight are coalesced into a single pending
// word, and the newest one wins. Updates that match the word already launched are
// suppressed.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   agc      AGC code; the attenuator word is its top ATT_BITS bits
//   upd      one-cycle strobe qualifying agc
//   sclk     attenuator serial clock
//   sdata    attenuator serial data, MSB first
//   le       attenuator latch enable, active high
//   busy     high while a write or its holdoff is in progress
//   att_cur  last word fully latched into the attenuator
//   drop     one-cycle pulse when a valid pending word is overwritten or cancelled
module agc_atten_writer #(
    parameter int unsigned AGC_BITS      = 8,
    parameter int unsigned ATT_BITS      = 6,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned LE_TICKS      = 2,
    parameter int unsigned HOLDOFF_TICKS = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AGC_BITS-1:0] agc,
    input  logic                upd,
    output logic                sclk,
    output logic                sdata,
    output logic                le,
    output logic                busy,
    output logic [ATT_BITS-1:0] att_cur,
    output logic                drop
);

    localparam int unsigned TICK_A   = (CLK_DIV > LE_TICKS) ? CLK_DIV : LE_TICKS;
    localparam int unsigned TICK_MAX = (TICK_A > HOLDOFF_TICKS) ? TICK_A : HOLDOFF_TICKS;
    localparam int unsigned TW       = $clog2(TICK_MAX + 1);
    localparam int unsigned BW       = $clog2(ATT_BITS + 1);

    localparam logic [TW-1:0] DIV_LAST  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LE_LAST   = TW'(LE_TICKS - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'((HOLDOFF_TICKS == 0) ? 0 : HOLDOFF_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(ATT_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch,
        StHoldoff
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [ATT_BITS-1:0] shreg_q, shreg_d;
    logic [ATT_BITS-1:0] tgt_q, tgt_d;
    logic [ATT_BITS-1:0] pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                le_q, le_d;
    logic                busy_q, busy_d;
    logic [ATT_BITS-1:0] att_cur_q, att_cur_d;
    logic                drop_q, drop_d;

    logic [ATT_BITS-1:0] w;
    assign w = agc[AGC_BITS-1 -: ATT_BITS];

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        le_d       = le_q;
        busy_d     = busy_q;
        att_cur_d  = att_cur_q;
        drop_d     = 1'b0;

        case (state_q)
            StIdle: begin
                sdata_d = 1'b0;
                if (pend_vld_q) begin
                    shreg_d    = pend_q;
                    tgt_d      = pend_q;
                    pend_vld_d = 1'b0;
                    busy_d     = 1'b1;
                    // The first bit goes out with the launch so it is set up for a full
                    // sclk-low half period.
                    sdata_d    = pend_q[ATT_BITS-1];
                    sclk_d     = 1'b0;
                    tick_d     = '0;
                    bit_d      = '0;
                    state_d    = StShift;
                end
            end

            StShift: begin
                if (tick_q != DIV_LAST) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            sdata_d = 1'b0;
                            le_d    = 1'b1;
                            state_d = StLatch;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            shreg_d = shreg_q << 1;
                            sdata_d = shreg_d[ATT_BITS-1];
                        end
                    end
                end
            end

            StLatch: begin
                if (tick_q != LE_LAST) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d    = '0;
                    le_d      = 1'b0;
                    att_cur_d = tgt_q;
                    if (HOLDOFF_TICKS == 0) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StHoldoff;
                    end
                end
            end

            StHoldoff: begin
                if (tick_q != HOLD_LAST) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d  = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        // Capture runs after any launch above, so it compares against the freshly launched
        // target and sees the pending slot already emptied.
        if (upd) begin
            if (!pend_vld_d) begin
                if (w != tgt_d) begin
                    pend_d     = w;
                    pend_vld_d = 1'b1;
                end
            end else begin
                drop_d = 1'b1;
                if (w != tgt_d) begin
                    pend_d = w;
                end else begin
                    pend_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tgt_q      <= '0;
            // Pending zero word forces the attenuator to a known state after reset.
            pend_q     <= '0;
            pend_vld_q <= 1'b1;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            le_q       <= 1'b0;
            busy_q     <= 1'b0;
            att_cur_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            le_q       <= le_d;
            busy_q     <= busy_d;
            att_cur_q  <= att_cur_d;
            drop_q     <= drop_d;
        end
    end

    assign sclk    = sclk_q;
    assign sdata   = sdata_q;
    assign le      = le_q;
    assign busy    = busy_q;
    assign att_cur = att_cur_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_agc_atten_writer.sv
// tb_agc_atten_writer: directed bench for agc_atten_writer.
// A negedge monitor decodes the serial stream into words and records timing marks.
// The stimulus sequence checks these against hand-computed values.
module tb_agc_atten_writer;

    localparam int unsigned AGC_BITS = 8;
    localparam int unsigned ATT_BITS = 6;
    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned LE_TICKS = 2;
    localparam int unsigned HOLDOFF  = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [AGC_BITS-1:0] agc = '0;
    logic                upd = 1'b0;
    logic                sclk;
    logic                sdata;
    logic                le;
    logic                busy;
    logic [ATT_BITS-1:0] att_cur;
    logic                drop;

    agc_atten_writer #(
        .AGC_BITS      (AGC_BITS),
        .ATT_BITS      (ATT_BITS),
        .CLK_DIV       (CLK_DIV),
        .LE_TICKS      (LE_TICKS),
        .HOLDOFF_TICKS (HOLDOFF)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .agc     (agc),
        .upd     (upd),
        .sclk    (sclk),
        .sdata   (sdata),
        .le      (le),
        .busy    (busy),
        .att_cur (att_cur),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    int            cyc = 0;
    int            rises_total = 0;
    int            busy_rises = 0;
    int            drops = 0;
    int            glitches = 0;
    int            busy_rise_cyc = 0;
    int            le_rise_cyc = 0;
    int            le_fall_cyc = 0;
    int            busy_fall_cyc = 0;
    int            nbits = 0;
    int            hi = 0;
    int            lehi = 0;
    int            last_bits = 0;
    int            last_hi = 0;
    int            last_le_hi = 0;
    logic [5:0]    cap = '0;
    logic [5:0]    att_at_fall = '0;
    logic          sclk_p = 1'b0;
    logic          le_p = 1'b0;
    logic          busy_p = 1'b0;
    logic          sdata_p = 1'b0;
    logic [5:0]    words[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            cap   = '0;
            nbits = 0;
            hi    = 0;
            lehi  = 0;
        end else begin
            if (sclk && !sclk_p) begin
                if (sdata !== sdata_p) glitches++;
                cap = {cap[4:0], sdata};
                nbits++;
                rises_total++;
            end
            if (sclk) hi++;
            if (le) lehi++;
            if (le && !le_p) begin
                words.push_back(cap);
                last_bits   = nbits;
                last_hi     = hi;
                le_rise_cyc = cyc;
                nbits       = 0;
                hi          = 0;
                cap         = '0;
            end
            if (!le && le_p) begin
                le_fall_cyc = cyc;
                last_le_hi  = lehi;
                lehi        = 0;
                att_at_fall = att_cur;
            end
            if (busy && !busy_p) begin
                busy_rises++;
                busy_rise_cyc = cyc;
            end
            if (!busy && busy_p) busy_fall_cyc = cyc;
            if (drop) drops++;
        end
        sclk_p  = sclk;
        le_p    = le;
        busy_p  = busy;
        sdata_p = sdata;
    end

    // All bench activity sits 1 time unit after a falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic upd_pulse(input logic [7:0] v);
        agc = v;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int n = 0;
        while (busy !== val && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, busy, val);
    endtask

    task automatic wait_write(input string tag);
        wait_busy(1'b1, 20, {tag, "_start"});
        wait_busy(1'b0, 400, {tag, "_done"});
    endtask

    task automatic check_write(input string tag, input logic [5:0] exp);
        check_eq({tag, "_word"}, words[$], exp);
        check_eq({tag, "_bits"}, last_bits, 6);
        check_eq({tag, "_sclk_hi"}, last_hi, 12);
        check_eq({tag, "_shift_len"}, le_rise_cyc - busy_rise_cyc, 24);
        check_eq({tag, "_le_len"}, last_le_hi, 2);
        check_eq({tag, "_holdoff"}, busy_fall_cyc - le_fall_cyc, 10);
        check_eq({tag, "_att_at_le_fall"}, att_at_fall, exp);
        check_eq({tag, "_att_cur"}, att_cur, exp);
    endtask

    initial begin
        int n0;
        int d0;
        int r0;
        int b0;
        int n;

        // Values held in reset
        repeat (3) tick();
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_sdata", sdata, 0);
        check_eq("rst_le", le, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_att_cur", att_cur, 0);
        check_eq("rst_drop", drop, 0);

        // Forced write of zero after release
        n0  = words.size();
        rst = 1'b1;
        wait_write("w0");
        check_write("w0", 6'h00);
        check_eq("w0_count", words.size() - n0, 1);

        // 0xA4 -> 0x29 (101001)
        d0 = drops;
        upd_pulse(8'hA4);
        wait_write("w29");
        check_write("w29", 6'h29);
        check_eq("w29_drops", drops - d0, 0);

        // Same word while idle: suppressed
        r0 = rises_total;
        b0 = busy_rises;
        upd_pulse(8'hA7);
        repeat (30) tick();
        check_eq("same_sclk_rises", rises_total - r0, 0);
        check_eq("same_busy_rises", busy_rises - b0, 0);
        check_eq("same_busy", busy, 0);

        // Back to zero, so the next 0xA4 is a real write
        upd_pulse(8'h00);
        wait_write("w00");
        check_write("w00", 6'h00);

        // Coalescing: 0x04, 0x08, 0x0C during the 0x29 write
        n0 = words.size();
        d0 = drops;
        upd_pulse(8'hA4);
        wait_busy(1'b1, 20, "co_start");
        upd_pulse(8'h10);
        upd_pulse(8'h20);
        upd_pulse(8'h30);
        wait_busy(1'b0, 400, "co_w1_done");
        check_write("co_w1", 6'h29);
        wait_write("co_w2");
        check_write("co_w2", 6'h0C);
        repeat (30) tick();
        check_eq("co_count", words.size() - n0, 2);
        check_eq("co_first", words[n0], 6'h29);
        check_eq("co_second", words[n0+1], 6'h0C);
        check_eq("co_drops", drops - d0, 2);

        // Cancel: pending 0x20 replaced by the in-flight word 0x29
        n0 = words.size();
        d0 = drops;
        upd_pulse(8'hA4);
        wait_busy(1'b1, 20, "cx_start");
        upd_pulse(8'h80);
        upd_pulse(8'hA4);
        wait_busy(1'b0, 400, "cx_done");
        check_write("cx", 6'h29);
        repeat (30) tick();
        check_eq("cx_count", words.size() - n0, 1);
        check_eq("cx_drops", drops - d0, 1);
        check_eq("cx_busy", busy, 0);

        // Reset in the middle of shifting 0x20 (first bit is 1)
        upd_pulse(8'h80);
        wait_busy(1'b1, 20, "rs_start");
        n = 0;
        while (sclk !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_eq("rs_sclk_high", sclk, 1);
        check_eq("rs_first_bit", sdata, 1);
        n0  = words.size();
        rst = 1'b0;
        #1;
        check_eq("rs_sclk", sclk, 0);
        check_eq("rs_sdata", sdata, 0);
        check_eq("rs_le", le, 0);
        check_eq("rs_busy", busy, 0);
        check_eq("rs_att_cur", att_cur, 0);
        tick();
        tick();
        rst = 1'b1;
        wait_write("rs_w");
        check_write("rs_w", 6'h00);
        check_eq("rs_count", words.size() - n0, 1);

        check_eq("sdata_stable", glitches, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
